seq_divider: RTL
================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the responder end of the dividend/divisor/Busy/Ready handshake used by the average-speed and other arithmetic clients of the bike computer.
- Accepts operands on a start strobe and computes one quotient bit per clock.
- Raises Ready for one cycle with quotient and remainder, and holds them until the next accepted start.
- Sits beside the top-level mux that selects which client drives the operands.

Parameters:
- WIDTH, 16, width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request strobe, sampled only while Busy==0
- dividend  input  WIDTH  numerator, latched on accepted start
- divisor  input  WIDTH  denominator, latched on accepted start
- dividerres  output  WIDTH  quotient, registered
- remainder  output  WIDTH  remainder, registered
- Busy  output  1  high while a division is in progress
- Ready  output  1  one-cycle pulse, result valid
- div_by_zero  output  1  registered flag, updated with Ready

Behaviour:
- Reset: on rst==1 at a clock edge, dividerres=0, remainder=0, Busy=0, Ready=0, div_by_zero=0, state=IDLE, iteration counter=0. Reset mid-calculation aborts the operation; no Ready is produced.
- States:
  - IDLE: Busy=0, Ready=0.
  - CALC: Busy=1.
  - DONE: Busy=0, Ready=1, lasts exactly one cycle.
- Transitions:
  - IDLE --start--> CALC. Operands are latched, the partial remainder is cleared, and the counter is loaded with WIDTH-1.
  - CALC: each cycle, shift the {partial remainder, dividend} pair left by one. If partial >= divisor, subtract the divisor and set the quotient LSB to 1; otherwise set it to 0. Decrement the counter; when the counter is 0, go to DONE and register the results.
  - DONE --start--> CALC (back-to-back accepted); DONE --no start--> IDLE.
- Latency: start sampled at edge N -> Busy=1 from N+1 to N+WIDTH; Ready=1 and Busy=0 in the cycle after edge N+WIDTH.
- Start is ignored while Busy==1. Operand changes during CALC have no effect.
- Partial remainder is WIDTH+1 bits internally, so the compare is free of overflow.
- Divisor==0: no special path. Restoring iteration naturally yields dividerres all-ones and remainder=dividend. div_by_zero=1 for that result and is cleared on the next non-zero result.
- Outputs hold their last values in IDLE and CALC. dividerres changes only in the cycle Ready rises.

Optional Feature:
- Macro: SEQ_DIVIDER_ROUND_EN.
- Defined: one extra ROUND state is inserted between CALC and DONE, so Ready comes one cycle later (edge N+WIDTH+1).
  - The quotient is incremented when 2*remainder >= divisor.
  - The result saturates at all-ones rather than wrapping.
  - remainder output is the unrounded remainder.
  - For divisor==0, rounding is suppressed.
- Undefined: the quotient is truncated, with the latency stated above.

Decomposition:
- bike_pkg holds:
  - DIV_WIDTH (16);
  - the divider state enum {IDLE, CALC, ROUND, DONE};
  - the counter width constant $clog2(DIV_WIDTH).
- Optional sub-module div_step: combinational single-bit restoring step (partial, next bit, divisor -> new partial, quotient bit). Instantiated once, in the CALC datapath.

Test Plan:
- 36000/11 with start pulse -> Busy high 16 cycles; Ready one cycle after; dividerres=3272, remainder=8, div_by_zero=0.
- 1000/6 -> dividerres=166, remainder=4. With SEQ_DIVIDER_ROUND_EN: dividerres=167 and Ready one cycle later.
- 1234/0 -> dividerres=0xFFFF, remainder=1234, div_by_zero=1. Next 10/2 -> dividerres=5, div_by_zero=0.
- 0xFFFF/1 -> dividerres=0xFFFF, remainder=0. With rounding enabled there is no wrap.
- During CALC of 1000/3: assert start with new operands 50/5 -> ignored, result 333 r1. Then start asserted in the DONE cycle -> accepted, Busy next cycle, result 10.
- rst asserted 5 cycles into a division -> all outputs 0 next cycle, no Ready pulse; a new start after reset completes normally.

Source files
------------

// File: rtl/bike_pkg.sv
// Shared constants and state encoding for the bike computer arithmetic blocks.
package bike_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] partial,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_partial,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The shifted value needs one extra bit so the compare cannot overflow;
  // after a successful subtract the result is below the divisor and fits in WIDTH bits.
  always_comb begin
    shifted     = {partial, next_bit};
    new_partial = shifted[WIDTH-1:0];
    q_bit       = 1'b0;
    if (shifted >= {1'b0, divisor}) begin
      new_partial = shifted[WIDTH-1:0] - divisor;
      q_bit       = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_ROUND_EN to add a ROUND state that rounds the quotient to nearest.
import bike_pkg::*;

module seq_divider #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] dividerres,
  output logic [WIDTH-1:0] remainder,
  output logic             Busy,
  output logic             Ready,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] new_partial;
  logic             q_bit;

  // work_q shifts dividend bits out of the top while quotient bits enter at the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .partial    (partial_q),
    .next_bit   (work_q[WIDTH-1]),
    .divisor    (divisor_q),
    .new_partial(new_partial),
    .q_bit      (q_bit)
  );

`ifdef SEQ_DIVIDER_ROUND_EN
  logic round_up;

  always_comb begin
    round_up = (divisor_q != '0) && ({partial_q, 1'b0} >= {1'b0, divisor_q}) && !(&work_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      partial_q   <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      dividerres  <= '0;
      remainder   <= '0;
      Busy        <= 1'b0;
      Ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      Ready <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= CALC;
            Busy      <= 1'b1;
            work_q    <= dividend;
            divisor_q <= divisor;
            partial_q <= '0;
            count_q   <= CW'(WIDTH - 1);
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          work_q    <= {work_q[WIDTH-2:0], q_bit};
          partial_q <= new_partial;
          count_q   <= count_q - 1'b1;
          if (count_q == '0) begin
`ifdef SEQ_DIVIDER_ROUND_EN
            state_q <= ROUND;
`else
            state_q     <= DONE;
            Busy        <= 1'b0;
            Ready       <= 1'b1;
            dividerres  <= {work_q[WIDTH-2:0], q_bit};
            remainder   <= new_partial;
            div_by_zero <= (divisor_q == '0);
`endif
          end
        end
`ifdef SEQ_DIVIDER_ROUND_EN
        // Saturation and divide-by-zero suppression are folded into round_up
        ROUND: begin
          state_q     <= DONE;
          Busy        <= 1'b0;
          Ready       <= 1'b1;
          dividerres  <= work_q + WIDTH'(round_up);
          remainder   <= partial_q;
          div_by_zero <= (divisor_q == '0);
        end
`endif
        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
